// File: rtl/traffic_pkg.sv
// Shared phase codes, timer state encoding and default counter width for the
// traffic phase timer.
package traffic_pkg;

  localparam int unsigned DW_W_DEF = 8;

  localparam logic [2:0] PH_INIT = 3'd0;
  localparam logic [2:0] PH_P1   = 3'd1;
  localparam logic [2:0] PH_P2   = 3'd2;
  localparam logic [2:0] PH_P3   = 3'd3;
  localparam logic [2:0] PH_P4   = 3'd4;

  typedef enum logic [2:0] {
    S_LOAD,
    S_COUNT,
    S_EXTEND,
    S_FIRE,
    S_WAIT
  } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clk divider producing a 1-clk tick every PRESCALE cycles;
// clr restarts the count at zero and masks the tick in that cycle.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || cnt_q == LAST) cnt_d = '0;
    else                      cnt_d = cnt_q + CW'(1);
    tick = !clr && (cnt_q == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_timer.sv
// Per-phase dwell timer feeding the light-sequencing FSM's step enable, with
// actuated main-road green. Optional pedestrian extension under PED_REQ_EN.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned PRESCALE  = 50_000_000,
  parameter int unsigned DW_W      = DW_W_DEF,
  parameter int unsigned DW_P1     = 20,
  parameter int unsigned MAX_MAIN  = 60,
  parameter int unsigned DW_P2     = 4,
  parameter int unsigned DW_P3     = 15,
  parameter int unsigned DW_P4     = 4,
  parameter int unsigned STALL_CYC = 4
`ifdef PED_REQ_EN
  ,
  parameter int unsigned PED_EXTRA = 5
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      phase,
  input  logic            side_req,
`ifdef PED_REQ_EN
  input  logic            ped_req,
`endif
  output logic            advance,
  output logic            sec_tick,
  output logic [DW_W-1:0] remaining,
  output logic            req_pending,
  output logic            stall
);

  localparam logic [DW_W-1:0] EXT_LOAD   = DW_W'(MAX_MAIN - DW_P1);
  localparam int unsigned     WCW        = $clog2(STALL_CYC + 1);
  localparam logic [WCW-1:0]  STALL_LAST = WCW'(STALL_CYC - 1);

  timer_state_e    state_q, state_d;
  logic [DW_W-1:0] remaining_q, remaining_d;
  logic [2:0]      phase_q, phase_d;
  logic [2:0]      phase_prev_q, phase_prev_d;
  logic [1:0]      side_sync_q, side_sync_d;
  logic            req_pending_q, req_pending_d;
  logic            stall_q, stall_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DW_W-1:0] load_val;
  logic            tick;
  logic            presc_clr;
  logic            enter_p3;

  assign presc_clr = (state_q == S_LOAD);

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (presc_clr),
    .tick(tick)
  );

`ifdef PED_REQ_EN
  localparam longint unsigned DW_SAT      = (64'd1 << DW_W) - 64'd1;
  localparam longint unsigned P3_PED_SUM  = 64'(DW_P3) + 64'(PED_EXTRA);
  localparam logic [DW_W-1:0] P3_PED_LOAD = DW_W'((P3_PED_SUM > DW_SAT) ? DW_SAT : P3_PED_SUM);

  logic [1:0] ped_sync_q, ped_sync_d;
  logic       ped_pending_q, ped_pending_d;

  always_comb begin
    ped_sync_d    = {ped_sync_q[0], ped_req};
    ped_pending_d = ped_pending_q;
    // Consuming the extension in the phase-3 load beats a same-cycle press.
    if (state_q == S_LOAD && phase == PH_P3 && ped_pending_q) ped_pending_d = 1'b0;
    else if (ped_sync_q[1])                                   ped_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ped_sync_q    <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      ped_sync_q    <= ped_sync_d;
      ped_pending_q <= ped_pending_d;
    end
  end
`endif

  always_comb begin
    load_val = '0;
    case (phase)
      PH_INIT: load_val = '0;
      PH_P1:   load_val = DW_W'(DW_P1);
      PH_P2:   load_val = DW_W'(DW_P2);
`ifdef PED_REQ_EN
      PH_P3:   load_val = ped_pending_q ? P3_PED_LOAD : DW_W'(DW_P3);
`else
      PH_P3:   load_val = DW_W'(DW_P3);
`endif
      PH_P4:   load_val = DW_W'(DW_P4);
      default: load_val = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    phase_d      = phase_q;
    stall_d      = stall_q;
    wait_cnt_d   = wait_cnt_q;
    phase_prev_d = phase;
    side_sync_d  = {side_sync_q[0], side_req};

    case (state_q)
      S_LOAD: begin
        remaining_d = load_val;
        phase_d     = phase;
        state_d     = S_COUNT;
      end
      S_COUNT: begin
        if (phase != phase_q) begin
          state_d = S_LOAD;
        end else if (phase <= PH_P4) begin
          if (remaining_q == '0) begin
            if (phase == PH_P1 && !req_pending_q) begin
              state_d     = S_EXTEND;
              remaining_d = EXT_LOAD;
            end else begin
              state_d = S_FIRE;
            end
          end else if (tick) begin
            remaining_d = remaining_q - DW_W'(1);
          end
        end
      end
      S_EXTEND: begin
        if (phase != phase_q)                          state_d = S_LOAD;
        else if (req_pending_q || remaining_q == '0)   state_d = S_FIRE;
        else if (tick)                                 remaining_d = remaining_q - DW_W'(1);
      end
      S_FIRE: begin
        phase_d    = phase;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (phase != phase_q) begin
          state_d = S_LOAD;
          stall_d = 1'b0;
        end else if (wait_cnt_q == STALL_LAST) begin
          stall_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    enter_p3      = (phase == PH_P3) && (phase_prev_q != PH_P3);
    req_pending_d = req_pending_q;
    if (enter_p3)                             req_pending_d = 1'b0;
    else if (side_sync_q[1] && phase != PH_P3) req_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LOAD;
      remaining_q   <= '0;
      phase_q       <= phase;
      phase_prev_q  <= phase;
      side_sync_q   <= '0;
      req_pending_q <= 1'b0;
      stall_q       <= 1'b0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      phase_q       <= phase_d;
      phase_prev_q  <= phase_prev_d;
      side_sync_q   <= side_sync_d;
      req_pending_q <= req_pending_d;
      stall_q       <= stall_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign advance     = (state_q == S_FIRE);
  assign sec_tick    = tick;
  assign remaining   = remaining_q;
  assign req_pending = req_pending_q;
  assign stall       = stall_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer with a small sequencing-FSM model
// that steps the phase on each advance pulse.
module tb_traffic_phase_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] phase;
  logic       side_req;
  logic       ped_req;
  logic       advance;
  logic       sec_tick;
  logic [7:0] remaining;
  logic       req_pending;
  logic       stall;

  int tests = 0;
  int fails = 0;
  bit fsm_en = 1'b1;

`ifdef PED_REQ_EN
  localparam int P3_PED_N = 2 + (1 + 5) * 4 + 2;
`else
  localparam int P3_PED_N = 2 + 1 * 4 + 2;
`endif

  traffic_phase_timer #(
    .PRESCALE (4),
    .DW_W     (8),
    .DW_P1    (2),
    .MAX_MAIN (5),
    .DW_P2    (1),
    .DW_P3    (1),
    .DW_P4    (1),
    .STALL_CYC(4)
`ifdef PED_REQ_EN
    ,
    .PED_EXTRA(5)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .phase      (phase),
    .side_req   (side_req),
`ifdef PED_REQ_EN
    .ped_req    (ped_req),
`endif
    .advance    (advance),
    .sec_tick   (sec_tick),
    .remaining  (remaining),
    .req_pending(req_pending),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] nxt(input logic [2:0] p);
    case (p)
      3'd0:    return 3'd1;
      3'd1:    return 3'd2;
      3'd2:    return 3'd3;
      3'd3:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  task automatic step();
    logic adv;
    adv = advance;
    @(posedge clk);
    #1;
    if (fsm_en && adv === 1'b1) phase = nxt(phase);
  endtask

  // Steps until the next advance; n counts clocks from the current cycle.
  task automatic next_adv(input int side_at, input int ped_at, output int n,
                          output int ticks, output int first_tick, output int gap_bad);
    int last;
    n = 0; ticks = 0; first_tick = -1; gap_bad = 0; last = -1;
    do begin
      step();
      n++;
      if (side_at > 0 && n == side_at)     side_req = 1'b1;
      if (side_at > 0 && n == side_at + 3) side_req = 1'b0;
      if (ped_at > 0 && n == ped_at)       ped_req = 1'b1;
      if (ped_at > 0 && n == ped_at + 3)   ped_req = 1'b0;
      if (sec_tick === 1'b1) begin
        ticks++;
        if (first_tick < 0) first_tick = n;
        else if (n - last != 4) gap_bad++;
        last = n;
      end
    end while (advance !== 1'b1 && n < 100);
    side_req = 1'b0;
    ped_req  = 1'b0;
  endtask

  task automatic test_reset();
    int n, t, ft, gb;
    rst = 1'b1; phase = 3'd0; side_req = 1'b0; ped_req = 1'b0;
    repeat (3) step();
    tests++; if (advance !== 1'b0) begin fails++; $display("FAIL reset_advance got %b want 0", advance); end
    tests++; if (sec_tick !== 1'b0) begin fails++; $display("FAIL reset_sec_tick got %b want 0", sec_tick); end
    tests++; if (remaining !== 8'd0) begin fails++; $display("FAIL reset_remaining got %0d want 0", remaining); end
    tests++; if (req_pending !== 1'b0) begin fails++; $display("FAIL reset_req_pending got %b want 0", req_pending); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    rst = 1'b0;
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 2) begin fails++; $display("FAIL reset_p0_latency got %0d want 2", n); end
  endtask

  task automatic test_extend_no_req();
    int n, t, ft, gb;
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 24) begin fails++; $display("FAIL ext_latency got %0d want 24", n); end
    tests++; if (req_pending !== 1'b0) begin fails++; $display("FAIL ext_req_pending got %b want 0", req_pending); end
    tests++; if (t != 5) begin fails++; $display("FAIL ext_tick_count got %0d want 5", t); end
    tests++; if (ft != 6) begin fails++; $display("FAIL ext_first_tick got %0d want 6", ft); end
    tests++; if (gb != 0) begin fails++; $display("FAIL ext_tick_period bad_gaps %0d want 0", gb); end
  endtask

  task automatic test_dwell_p2();
    int n, t, ft, gb;
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 8) begin fails++; $display("FAIL p2_latency got %0d want 8", n); end
    tests++; if (t != 1) begin fails++; $display("FAIL p2_tick_count got %0d want 1", t); end
    tests++; if (ft != 6) begin fails++; $display("FAIL p2_first_tick got %0d want 6", ft); end
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 8) begin fails++; $display("FAIL p3_latency got %0d want 8", n); end
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 8) begin fails++; $display("FAIL p4_latency got %0d want 8", n); end
  endtask

  task automatic test_side_req();
    int n, t, ft, gb;
    next_adv(15, 0, n, t, ft, gb);
    tests++; if (n != 19) begin fails++; $display("FAIL side_latency got %0d want 19", n); end
    tests++; if (req_pending !== 1'b1) begin fails++; $display("FAIL side_req_pending got %b want 1", req_pending); end
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 8) begin fails++; $display("FAIL side_p2_latency got %0d want 8", n); end
    tests++; if (req_pending !== 1'b1) begin fails++; $display("FAIL side_p2_pending got %b want 1", req_pending); end
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 8) begin fails++; $display("FAIL side_p3_latency got %0d want 8", n); end
    tests++; if (req_pending !== 1'b0) begin fails++; $display("FAIL side_p3_clear got %b want 0", req_pending); end
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 8) begin fails++; $display("FAIL side_p4_latency got %0d want 8", n); end
  endtask

  task automatic test_ped();
    int n, t, ft, gb;
    next_adv(0, 5, n, t, ft, gb);
    tests++; if (n != 24) begin fails++; $display("FAIL ped_p1_latency got %0d want 24", n); end
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 8) begin fails++; $display("FAIL ped_p2_latency got %0d want 8", n); end
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != P3_PED_N) begin fails++; $display("FAIL ped_p3_latency got %0d want %0d", n, P3_PED_N); end
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 8) begin fails++; $display("FAIL ped_p4_latency got %0d want 8", n); end
  endtask

  task automatic test_stall();
    int n, t, ft, gb;
    logic exp_stall;
    fsm_en = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp_stall = (i >= 5);
      tests++; if (stall !== exp_stall) begin fails++; $display("FAIL stall_c%0d got %b want %b", i, stall, exp_stall); end
      tests++; if (advance !== 1'b0) begin fails++; $display("FAIL stall_no_adv_c%0d got %b want 0", i, advance); end
    end
    phase = 3'd1;
    step();
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_clear got %b want 0", stall); end
    fsm_en = 1'b1;
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 22) begin fails++; $display("FAIL stall_resume_latency got %0d want 22", n); end
  endtask

  task automatic test_rst_abort();
    int n, t, ft, gb;
    repeat (5) step();
    rst = 1'b1; phase = 3'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (advance !== 1'b0) begin fails++; $display("FAIL abort_adv_c%0d got %b want 0", i, advance); end
    end
    tests++; if (remaining !== 8'd0) begin fails++; $display("FAIL abort_remaining got %0d want 0", remaining); end
    rst = 1'b0;
    next_adv(0, 0, n, t, ft, gb);
    tests++; if (n != 2) begin fails++; $display("FAIL abort_restart_latency got %0d want 2", n); end
  endtask

  initial begin
    test_reset();
    test_extend_no_req();
    test_dwell_p2();
    test_side_req();
    test_ped();
    test_stall();
    test_rst_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
